// File: rtl/mac_array_seq.sv
// mac_array_seq: per-job sequencer for the mac_tile array (reset, kernel load/flush, execute, drain).
// Latency: outputs are registered decodes of the state register; inst_w trails l0_rd by one cycle.
// Backpressure: none; start is only sampled in IDLE and requests arriving while busy are dropped.
// Ports: clk/reset (sync, active-low), start/mode/skip_kload/num_vec job request,
//        busy/done status, ctrl/array_rst/inst_w/l0_rd to the array and L0, psum_valid south-edge strobe.
module mac_array_seq #(
    parameter int COL    = 8,
    parameter int ROW    = 8,
    parameter int LEN_BW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              skip_kload,
    input  logic [LEN_BW-1:0] num_vec,
    output logic              busy,
    output logic              done,
    output logic              ctrl,
    output logic              array_rst,
    output logic [1:0]        inst_w,
    output logic              l0_rd,
    output logic              psum_valid
);
    localparam int DLY = ROW + COL - 1;
    localparam int DW  = $clog2(ROW + COL + 1);
    localparam int CW  = (LEN_BW > DW) ? LEN_BW : DW;

    localparam logic [CW-1:0] COL_M1   = CW'(COL - 1);
    localparam logic [CW-1:0] DRAIN_M1 = CW'(ROW + COL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARST, S_KLOAD, S_KFLUSH, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LEN_BW-1:0] num_q, num_d;
    logic              ctrl_q, ctrl_d;
    logic              wt_valid_q, wt_valid_d;
    logic              wt_mode_q, wt_mode_d;
    logic [1:0]        phase_q, phase_d;
    logic [1:0]        inst_w_q, inst_w_d;
    logic              l0_rd_q, l0_rd_d;
    logic              array_rst_q, array_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DLY-1:0]    dly_q, dly_d;

    // Counter holds remaining cycles minus one in the current state; a state
    // is left when it reads zero, so a count of N is loaded as N-1 (no wrap).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        ctrl_d     = ctrl_q;
        wt_valid_d = wt_valid_q;
        wt_mode_d  = wt_mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_vec == '0) begin
                        state_d = S_DONE;
                    end else begin
                        ctrl_d = mode;
                        num_d  = num_vec;
                        if (skip_kload && wt_valid_q && (mode == wt_mode_q)) begin
                            state_d = S_EXEC;
                            cnt_d   = CW'(num_vec) - CW'(1);
                        end else begin
                            state_d = S_ARST;
                        end
                    end
                end
            end
            S_ARST: begin
                // Tiles lose their captured weights here, so the resident kernel is gone.
                wt_valid_d = 1'b0;
                state_d    = S_KLOAD;
                cnt_d      = COL_M1;
            end
            S_KLOAD: begin
                if (cnt_q == '0) begin
                    state_d    = S_KFLUSH;
                    cnt_d      = COL_M1;
                    wt_valid_d = 1'b1;
                    wt_mode_d  = ctrl_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_KFLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                    cnt_d   = CW'(num_q) - CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = DRAIN_M1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered output decodes. inst_w takes one extra stage so it lines up
    // with L0 data, which appears one cycle after the read strobe.
    always_comb begin
        array_rst_d = (state_q == S_ARST);
        l0_rd_d     = (state_q == S_KLOAD) || (state_q == S_EXEC);
        phase_d     = (state_q == S_KLOAD) ? 2'b01 :
                      (state_q == S_EXEC)  ? 2'b10 : 2'b00;
        inst_w_d    = phase_q;
        busy_d      = (state_q != S_IDLE);
        done_d      = (state_q == S_DONE);
        dly_d       = {dly_q[DLY-2:0], inst_w_q[1]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            ctrl_q      <= 1'b0;
            wt_valid_q  <= 1'b0;
            wt_mode_q   <= 1'b0;
            phase_q     <= 2'b00;
            inst_w_q    <= 2'b00;
            l0_rd_q     <= 1'b0;
            array_rst_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            ctrl_q      <= ctrl_d;
            wt_valid_q  <= wt_valid_d;
            wt_mode_q   <= wt_mode_d;
            phase_q     <= phase_d;
            inst_w_q    <= inst_w_d;
            l0_rd_q     <= l0_rd_d;
            array_rst_q <= array_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dly_q       <= dly_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ctrl       = ctrl_q;
    assign array_rst  = array_rst_q;
    assign inst_w     = inst_w_q;
    assign l0_rd      = l0_rd_q;
    assign psum_valid = dly_q[DLY-1];

endmodule

// File: tb/tb_mac_array_seq.sv
// Bench for mac_array_seq: per-cycle output vectors predicted from job timing.
// Latency: expectations are indexed by cycles after the accept edge.
// Backpressure: n/a; the bench drives start and watches every cycle.
module tb_mac_array_seq;
    localparam int COL = 8;
    localparam int ROW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic       skip_kload;
    logic [7:0] num_vec;
    logic       busy, done, ctrl, array_rst, l0_rd, psum_valid;
    logic [1:0] inst_w;
    logic [7:0] outs;

    int n_checks = 0;
    int n_fail   = 0;
    bit cur_ctrl = 1'b0;

    mac_array_seq #(.COL(COL), .ROW(ROW), .LEN_BW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .skip_kload (skip_kload),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .ctrl       (ctrl),
        .array_rst  (array_rst),
        .inst_w     (inst_w),
        .l0_rd      (l0_rd),
        .psum_valid (psum_valid)
    );

    always #5 clk = ~clk;

    // {busy, done, ctrl, array_rst, inst_w[1:0], l0_rd, psum_valid}
    assign outs = {busy, done, ctrl, array_rst, inst_w, l0_rd, psum_valid};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got={b,d,c,r,iw,rd,pv}=%b exp=%b", tag, got, exp);
        end
    endtask

    // Expected outputs k cycles after the accept edge, from the job timeline:
    // optional ARST + KLOAD(COL) + KFLUSH(COL), EXEC(n), DRAIN(ROW+COL), DONE.
    function automatic logic [7:0] exp_vec(input int k, input bit reload, input int n, input bit c);
        int  off, e;
        bit  b, d, r, rd, pv;
        logic [1:0] iw;
        if (n == 0) return {(k == 1), (k == 1), c, 5'b0};
        off = reload ? 2 * COL + 1 : 0;
        e   = 1 + off + n + ROW + COL;
        b   = (k >= 1) && (k <= e);
        d   = (k == e);
        r   = reload && (k == 1);
        rd  = (reload && k >= 2 && k <= COL + 1) || (k >= off + 1 && k <= off + n);
        if (reload && k >= 3 && k <= COL + 2)  iw = 2'b01;
        else if (k >= off + 2 && k <= off + n + 1) iw = 2'b10;
        else iw = 2'b00;
        pv  = (k >= off + ROW + COL + 1) && (k <= off + ROW + COL + n);
        return {b, d, c, r, iw, rd, pv};
    endfunction

    task automatic run_job(input string name, input bit skip, input bit md, input int n, input bit reload);
        logic [7:0] exp_q[$];
        int  last;
        bit  c;
        c    = (n == 0) ? cur_ctrl : md;
        last = (n == 0) ? 2 : (2 + (reload ? 2 * COL + 1 : 0) + n + ROW + COL);
        for (int k = 0; k <= last; k++) exp_q.push_back(exp_vec(k, reload, n, c));
        @(negedge clk);
        start = 1'b1; mode = md; skip_kload = skip; num_vec = n[7:0];
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_k%0d", name, k), outs, exp_q.pop_front());
            if (k == 0) start = 1'b0;
        end
        cur_ctrl = c;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        reset = 1'b0; start = 1'b0; mode = 1'b0; skip_kload = 1'b0; num_vec = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", outs, 8'b0001_0000);
        reset = 1'b1;
        @(posedge clk); #1 chk("arst_fall", outs, 8'h00);

        run_job("full_m0",     1'b0, 1'b0, 4,   1'b1);  // first load after reset
        run_job("skip_m0",     1'b1, 1'b0, 4,   1'b0);  // resident kernel reused
        run_job("skip_m1_ref", 1'b1, 1'b1, 3,   1'b1);  // mode mismatch forces reload
        run_job("nv0",         1'b0, 1'b1, 0,   1'b0);
        run_job("skip_max",    1'b1, 1'b1, 255, 1'b0);  // longest count, no wrap

        // Mid-job: extra start during EXEC is ignored, then reset at cycle 12.
        for (int k = 0; k <= 11; k++) exp_q.push_back(exp_vec(k, 1'b0, 20, 1'b1));
        @(negedge clk);
        start = 1'b1; mode = 1'b1; skip_kload = 1'b1; num_vec = 8'd20;
        for (int k = 0; k <= 11; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_k%0d", k), outs, exp_q.pop_front());
            if (k == 0) start = 1'b0;
            if (k == 4) begin start = 1'b1; mode = 1'b0; num_vec = 8'd0; end
            if (k == 5) start = 1'b0;
            if (k == 11) reset = 1'b0;
        end
        @(posedge clk); #1 chk("mid_rst", outs, 8'b0001_0000);
        @(posedge clk); #1 chk("mid_rst_hold", outs, 8'b0001_0000);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 chk($sformatf("post_rst_idle%0d", k), outs, 8'h00);
        end
        cur_ctrl = 1'b0;
        run_job("post_rst_skip", 1'b1, 1'b1, 2, 1'b1);  // weights invalidated by reset

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_array_seq.md
# mac_array_seq

Sequencer for the 2-D `mac_tile` array.
- Per job, it generates the west-edge instruction stream (`inst_w`), the array reset, the activation-mode select (`ctrl`) and the L0 read strobe.
- It tracks results leaving the array's south edge and signals job completion.
- It sits between the top-level core controller and the array/L0 pair.
- It elides weight reload when the loaded kernel is still valid for the requested mode.

## Interface
- `col`, 8: array columns (tiles per row); weight load/flush length.
- `row`, 8: array rows; used for drain latency.
- `len_bw`, 8: width of the vector-count field.

- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low: 0 at an edge resets the block.
- `start`  in  1  job request; sampled only in IDLE.
- `mode`  in  1  0 = 2-bit activations, 1 = 4-bit activations; sampled with `start`.
- `skip_kload`  in  1  reuse resident weights if legal; sampled with `start`.
- `num_vec`  in  `len_bw`  activation vectors to execute; sampled with `start`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `ctrl`  out  1  mode to every tile; latched at job accept.
- `array_rst`  out  1  active-high reset to all tiles.
- `inst_w`  out  2  to array west edge: bit1 = execute, bit0 = kernel load.
- `l0_rd`  out  1  L0 read strobe; data appears one cycle later.
- `psum_valid`  out  1  south-edge `out_s` values valid this cycle.

## Operation
- **States:** IDLE, ARST, KLOAD, KFLUSH, EXEC, DRAIN, DONE.
- **IDLE:**
  - On `start`=1 with `num_vec`=0: go to DONE. No array activity and no `array_rst`.
  - Otherwise latch `mode` into `ctrl` and `num_vec` into the job count.
  - If `skip_kload`=1 and `wt_valid`=1 and latched mode == `wt_mode`: go to EXEC. Else go to ARST.
- **ARST (1 cycle):**
  - `array_rst`=1; clear `wt_valid`.
  - This re-arms each tile's one-shot weight capture.
- **KLOAD (`col` cycles):**
  - Phase = load (01); `l0_rd`=1.
  - On exit set `wt_valid`=1 and `wt_mode`=`ctrl`.
- **KFLUSH (`col` cycles):**
  - Phase = idle (00); `l0_rd`=0.
  - Lets load instructions propagate out of the array.
- **EXEC (`num_vec` cycles):**
  - Phase = execute (10); `l0_rd`=1.
- **DRAIN (`row`+`col` cycles):**
  - Phase = 00.
  - Covers the final `psum_valid` cycles.
- **DONE (1 cycle):** `done`=1, then go to IDLE.
- **`inst_w`:** equals the phase registered one cycle later, matching L0 read latency.
- **`psum_valid`:** equals `inst_w[1]` delayed by `row`+`col`−1 cycles through a shift register.
- **Counters:**
  - One down-counter, reloaded on every state entry; width = max(`len_bw`, clog2(`row`+`col`+1)).
  - No wrap: `num_vec`=2^`len_bw`−1 executes exactly that many vectors.
- **`busy`:** 1 in every state except IDLE, including DONE.
- **`ctrl` stability:** `ctrl` is stable for the entire job and changes only on the accept edge.
- **`start` outside IDLE:** ignored; no queuing.
- **`wt_valid`/`wt_mode`:** held across jobs and cleared only by `reset` or ARST.

## Timing
- **Reset values:**

  | Output | Reset value |
  |---|---|
  | `busy` | 0 |
  | `done` | 0 |
  | `ctrl` | 0 |
  | `inst_w` | 00 |
  | `l0_rd` | 0 |
  | `psum_valid` | 0 |
  | `array_rst` | 1 |

  - Also cleared by reset: `wt_valid`=0, delay line all zero, state IDLE.
  - `array_rst` falls on the first edge after `reset` returns high.
- **Cycle numbering:** cycle k = after edge k; `start` is accepted at edge 0.
- **Full job** (with reload), N = `num_vec`:
  - ARST: cycle 1.
  - KLOAD: cycles 2..`col`+1.
  - KFLUSH: next `col` cycles.
  - EXEC: next N cycles.
  - DRAIN: next `row`+`col` cycles.
  - `done` at cycle 2+3·`col`+`row`+N.
- **Skipped load:** EXEC starts at cycle 1; `done` at cycle 1+N+`row`+`col`.
- **`num_vec`=0:** `done` at cycle 1, `busy`=1 only at cycle 1.
- **Reset mid-job:** all outputs return to reset values on the next edge; the job is lost; `done` is not pulsed.

## Test plan
- **Full load, reset, col=row=8, mode=0, num_vec=4, start at edge 0:**
  - `array_rst` at cycle 1; `l0_rd` cycles 2–9 and 18–21.
  - `inst_w`=01 at cycles 3–10, =10 at cycles 19–22.
  - `psum_valid` cycles 34–37; `done` at 38; `busy` 0 at 39.
- **Repeat with skip_kload=1, mode=0:** no `array_rst`; `inst_w`=10 at cycles 2–5; `psum_valid` 17–20; `done` at 21.
- **Skip with mode=1 after a mode=0 load:** skip refused; ARST/KLOAD occur; `ctrl`=1 from cycle 1 to `done`.
- **num_vec=0:** `done` at cycle 1; `inst_w`, `l0_rd`, `array_rst` stay 0.
- **start pulsed during EXEC, and `reset`=0 at cycle 12:**
  - The extra `start` has no effect.
  - After reset: `busy`=0, `inst_w`=00, `array_rst`=1, `done` never pulses.
  - A subsequent skip_kload=1 request still performs ARST/KLOAD.
